// File: rtl/fsm_lock_pkg.sv
// Shared state encodings and key helpers for the parametrised password lock.
package fsm_lock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_ENTRY    = 2'd0;
    localparam state_t ST_UNLOCKED = 2'd1;
    localparam state_t ST_PROGRAM  = 2'd2;
    localparam state_t ST_LOCKOUT  = 2'd3;

    localparam int unsigned MAX_KEY_W = 256;

    // Digit i of a packed key; digit 0 sits in the most significant position.
    function automatic logic [31:0] key_digit(input logic [MAX_KEY_W-1:0] key,
                                              input int unsigned len,
                                              input int unsigned dig_w,
                                              input int unsigned i);
        logic [MAX_KEY_W-1:0] mask;
        logic [MAX_KEY_W-1:0] sh;
        mask = (MAX_KEY_W'(1) << dig_w) - MAX_KEY_W'(1);
        sh   = key >> ((len - 1 - i) * dig_w);
        return 32'(sh & mask);
    endfunction

endpackage

// File: rtl/fsm_lock_keyram.sv
// Key storage: P_LEN digits, reset-loaded from P_KEY, one write port and one async read port.
module fsm_lock_keyram
    import fsm_lock_pkg::*;
#(
    parameter int unsigned P_DIG_W = 4,
    parameter int unsigned P_LEN   = 7,
    parameter logic [P_LEN*P_DIG_W-1:0] P_KEY = 28'h3044238
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(P_LEN)-1:0]   idx,
    input  logic [P_DIG_W-1:0]         wdata,
    output logic [P_DIG_W-1:0]         rd_data_c
);

    logic [P_DIG_W-1:0] mem [P_LEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < P_LEN; i++) begin
                mem[i] <= P_DIG_W'(key_digit(MAX_KEY_W'(P_KEY), P_LEN, P_DIG_W, i));
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rd_data_c = (32'(idx) < P_LEN) ? mem[idx] : '0;

endmodule

// File: rtl/fsm_lock_param.sv
// Parametrised digit lock: entry with thermometer progress, key reprogramming,
// failed-attempt counting with timed lockout, and explicit relock.
module fsm_lock_param
    import fsm_lock_pkg::*;
#(
    parameter int unsigned P_DIG_W    = 4,
    parameter int unsigned P_LEN      = 7,
    parameter logic [P_LEN*P_DIG_W-1:0] P_KEY = 28'h3044238,
    parameter int unsigned P_MAX_FAIL = 3,
    parameter int unsigned P_LOCKOUT  = 16
) (
    input  logic                              clk,
    input  logic                              i_Rst,
    input  logic                              i_CE,
    input  logic                              i_set_data,
    input  logic [P_DIG_W-1:0]                iv_data,
    input  logic                              i_relock,
    input  logic                              i_prog,
    output logic [P_LEN-1:0]                  o_acknowledge,
    output logic                              o_unlocked,
    output logic                              o_prog_active,
    output logic                              o_locked_out,
    output logic [$clog2(P_MAX_FAIL+1)-1:0]   ov_fail_cnt
);

    localparam int unsigned IDX_W  = $clog2(P_LEN);
    localparam int unsigned FAIL_W = $clog2(P_MAX_FAIL + 1);
    localparam int unsigned TMR_W  = $clog2(P_LOCKOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_LEN - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [P_LEN-1:0]    ack_nxt;
    logic [FAIL_W-1:0]   fail_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                key_we_c;
    logic [P_DIG_W-1:0]  key_rd_c;
    logic                digit_c;

    assign digit_c = i_CE && !i_set_data;

    fsm_lock_keyram #(
        .P_DIG_W (P_DIG_W),
        .P_LEN   (P_LEN),
        .P_KEY   (P_KEY)
    ) u_keyram (
        .clk       (clk),
        .rst       (i_Rst),
        .we        (key_we_c),
        .idx       (idx),
        .wdata     (iv_data),
        .rd_data_c (key_rd_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= ST_ENTRY;
            idx           <= '0;
            timer         <= '0;
            o_acknowledge <= '0;
            ov_fail_cnt   <= '0;
            o_unlocked    <= 1'b0;
            o_prog_active <= 1'b0;
            o_locked_out  <= 1'b0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            timer         <= timer_nxt;
            o_acknowledge <= ack_nxt;
            ov_fail_cnt   <= fail_nxt;
            o_unlocked    <= (state_nxt == ST_UNLOCKED);
            o_prog_active <= (state_nxt == ST_PROGRAM);
            o_locked_out  <= (state_nxt == ST_LOCKOUT);
        end
    end

    // Next-state logic; with i_CE low every register holds.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ack_nxt   = o_acknowledge;
        fail_nxt  = ov_fail_cnt;
        timer_nxt = timer;
        key_we_c  = 1'b0;
        if (i_CE) begin
            case (state)
                ST_ENTRY: begin
                    if (digit_c) begin
                        if (iv_data == key_rd_c) begin
                            ack_nxt[idx] = 1'b1;
                            if (idx == IDX_LAST) begin
                                state_nxt = ST_UNLOCKED;
                                idx_nxt   = '0;
                                fail_nxt  = '0;
                                ack_nxt   = '1;
                            end else begin
                                idx_nxt = idx + IDX_W'(1);
                            end
                        end else begin
                            ack_nxt = '0;
                            idx_nxt = '0;
                            // Reaching the limit freezes the count until the lockout expires.
                            if (ov_fail_cnt == FAIL_W'(P_MAX_FAIL - 1)) begin
                                state_nxt = ST_LOCKOUT;
                                fail_nxt  = FAIL_W'(P_MAX_FAIL);
                                timer_nxt = TMR_W'(P_LOCKOUT);
                            end else begin
                                fail_nxt = ov_fail_cnt + FAIL_W'(1);
                            end
                        end
                    end
                end
                ST_UNLOCKED: begin
                    ack_nxt = '1;
                    if (i_relock) begin
                        state_nxt = ST_ENTRY;
                        ack_nxt   = '0;
                        idx_nxt   = '0;
                    end else if (i_prog) begin
                        state_nxt = ST_PROGRAM;
                        ack_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
                ST_PROGRAM: begin
                    if (i_relock) begin
                        state_nxt = ST_ENTRY;
                        ack_nxt   = '0;
                        idx_nxt   = '0;
                    end else if (digit_c) begin
                        key_we_c     = 1'b1;
                        ack_nxt[idx] = 1'b1;
                        if (idx == IDX_LAST) begin
                            state_nxt = ST_ENTRY;
                            ack_nxt   = '0;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                ST_LOCKOUT: begin
                    ack_nxt = '0;
                    idx_nxt = '0;
                    if (timer <= TMR_W'(1)) begin
                        state_nxt = ST_ENTRY;
                        timer_nxt = '0;
                        fail_nxt  = '0;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_ENTRY;
                    idx_nxt   = '0;
                    ack_nxt   = '0;
                    fail_nxt  = '0;
                    timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_lock_param.sv
// Self-checking bench for fsm_lock_param: directed plan followed by randomized traffic vs a behavioural model.
module tb_fsm_lock_param;

    localparam int unsigned DW     = 4;
    localparam int unsigned LEN    = 7;
    localparam logic [27:0] KEY    = 28'h3044238;
    localparam int unsigned MAXF   = 3;
    localparam int unsigned LOCKT  = 16;
    localparam int unsigned FW     = $clog2(MAXF + 1);

    logic             clk;
    logic             i_Rst;
    logic             i_CE;
    logic             i_set_data;
    logic [DW-1:0]    iv_data;
    logic             i_relock;
    logic             i_prog;
    logic [LEN-1:0]   o_acknowledge;
    logic             o_unlocked;
    logic             o_prog_active;
    logic             o_locked_out;
    logic [FW-1:0]    ov_fail_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0=entry 1=unlocked 2=program 3=lockout
    int m_key [LEN];
    int m_mode;
    int m_pos;
    int m_fails;
    int m_tmr;

    fsm_lock_param #(
        .P_DIG_W    (DW),
        .P_LEN      (LEN),
        .P_KEY      (KEY),
        .P_MAX_FAIL (MAXF),
        .P_LOCKOUT  (LOCKT)
    ) dut (
        .clk           (clk),
        .i_Rst         (i_Rst),
        .i_CE          (i_CE),
        .i_set_data    (i_set_data),
        .iv_data       (iv_data),
        .i_relock      (i_relock),
        .i_prog        (i_prog),
        .o_acknowledge (o_acknowledge),
        .o_unlocked    (o_unlocked),
        .o_prog_active (o_prog_active),
        .o_locked_out  (o_locked_out),
        .ov_fail_cnt   (ov_fail_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < int'(LEN); i++) begin
            m_key[i] = int'((KEY >> ((int'(LEN) - 1 - i) * int'(DW))) & 28'hF);
        end
        m_mode  = 0;
        m_pos   = 0;
        m_fails = 0;
        m_tmr   = 0;
    endtask

    task automatic model_step(input logic ce, input logic sd, input int d,
                              input logic rl, input logic pg);
        bit dig;
        dig = !sd;
        if (!ce) return;
        case (m_mode)
            0: if (dig) begin
                if (d == m_key[m_pos]) begin
                    m_pos++;
                    if (m_pos == int'(LEN)) begin
                        m_mode  = 1;
                        m_pos   = 0;
                        m_fails = 0;
                    end
                end else begin
                    m_pos = 0;
                    m_fails++;
                    if (m_fails == int'(MAXF)) begin
                        m_mode = 3;
                        m_tmr  = int'(LOCKT);
                    end
                end
            end
            1: if (rl) begin
                m_mode = 0; m_pos = 0;
            end else if (pg) begin
                m_mode = 2; m_pos = 0;
            end
            2: if (rl) begin
                m_mode = 0; m_pos = 0;
            end else if (dig) begin
                m_key[m_pos] = d;
                m_pos++;
                if (m_pos == int'(LEN)) begin
                    m_mode = 0; m_pos = 0;
                end
            end
            default: begin
                m_tmr--;
                if (m_tmr == 0) begin
                    m_mode = 0; m_fails = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string tag);
        logic [LEN-1:0] e_ack;
        if (m_mode == 1)      e_ack = '1;
        else if (m_mode == 3) e_ack = '0;
        else                  e_ack = LEN'((1 << m_pos) - 1);
        checks++;
        assert (o_acknowledge === e_ack) else begin
            failures++;
            $error("FAIL %s ack got=%h exp=%h", tag, o_acknowledge, e_ack);
        end
        checks++;
        assert (o_unlocked === (m_mode == 1)) else begin
            failures++;
            $error("FAIL %s unlocked got=%b exp=%b", tag, o_unlocked, m_mode == 1);
        end
        checks++;
        assert (o_prog_active === (m_mode == 2)) else begin
            failures++;
            $error("FAIL %s prog_active got=%b exp=%b", tag, o_prog_active, m_mode == 2);
        end
        checks++;
        assert (o_locked_out === (m_mode == 3)) else begin
            failures++;
            $error("FAIL %s locked_out got=%b exp=%b", tag, o_locked_out, m_mode == 3);
        end
        checks++;
        assert (ov_fail_cnt === FW'(m_fails)) else begin
            failures++;
            $error("FAIL %s fail_cnt got=%0d exp=%0d", tag, ov_fail_cnt, m_fails);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic ce, input logic sd, input int d,
                        input logic rl, input logic pg, input string tag);
        i_CE       = ce;
        i_set_data = sd;
        iv_data    = DW'(d);
        i_relock   = rl;
        i_prog     = pg;
        @(posedge clk);
        model_step(ce, sd, d, rl, pg);
        #1;
        check(tag);
    endtask

    task automatic digit(input int d, input string tag);
        step(1'b1, 1'b0, d, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        i_CE = 1'b1; i_set_data = 1'b1; iv_data = '0; i_relock = 1'b0; i_prog = 1'b0;
        i_Rst = 1'b1;
        #2;
        model_reset();
        check(tag);
        i_Rst = 1'b0;
    endtask

    task automatic enter_seq(input logic [27:0] seq, input string tag);
        for (int i = 0; i < int'(LEN); i++) begin
            digit(int'((seq >> ((int'(LEN) - 1 - i) * 4)) & 28'hF), tag);
        end
    endtask

    initial begin
        logic [3:0] exp_acks [7];
        exp_acks = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        do_reset("reset");
        chk("reset_ack", 32'(o_acknowledge), 32'h0);

        // Default key unlocks with a growing thermometer.
        for (int i = 0; i < int'(LEN); i++) begin
            digit(m_key[i], "entry");
            chk("thermo", 32'(o_acknowledge), (i == int'(LEN) - 1) ? 32'h7F : 32'((1 << (i + 1)) - 1));
        end
        chk("unlocked", 32'(o_unlocked), 32'h1);

        // Relock, then a mismatch restarts and counts one failure.
        step(1'b1, 1'b1, 0, 1'b1, 1'b0, "relock");
        digit(3, "e3"); digit(0, "e0"); digit(5, "e5_bad");
        chk("fail1_ack", 32'(o_acknowledge), 32'h0);
        chk("fail1_cnt", 32'(ov_fail_cnt), 32'h1);
        digit(3, "restart");
        chk("restart_ack", 32'(o_acknowledge), 32'h1);

        // Three wrong digits -> lockout for exactly LOCKT enabled cycles.
        do_reset("reset2");
        digit(9, "w1"); digit(9, "w2"); digit(9, "w3");
        chk("locked", 32'(o_locked_out), 32'h1);
        for (int i = 0; i < int'(LOCKT); i++) begin
            if (i == 5) step(1'b0, 1'b0, 3, 1'b0, 1'b0, "lock_ce0");
            digit(m_key[i % int'(LEN)], "lock_dig");
        end
        chk("lock_exit", 32'(o_locked_out), 32'h0);
        chk("lock_cnt0", 32'(ov_fail_cnt), 32'h0);
        enter_seq(28'h3044238, "post_lock");
        chk("post_lock_unl", 32'(o_unlocked), 32'h1);

        // Reprogram to 1111111.
        step(1'b1, 1'b1, 0, 1'b0, 1'b1, "prog");
        chk("prog_active", 32'(o_prog_active), 32'h1);
        enter_seq(28'h1111111, "prog_wr");
        chk("prog_done", 32'(o_prog_active), 32'h0);
        digit(3, "old_key");
        chk("old_key_fail", 32'(ov_fail_cnt), 32'h1);
        enter_seq(28'h1111111, "new_key");
        chk("new_key_unl", 32'(o_unlocked), 32'h1);

        // Clock enable low freezes progress.
        step(1'b1, 1'b1, 0, 1'b1, 1'b0, "relock2");
        digit(1, "ce_a"); digit(1, "ce_b");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1, 1'b0, 1'b0, "ce_hold");
        chk("ce_hold_ack", 32'(o_acknowledge), 32'h3);

        // Reset in the middle of programming restores the default key.
        for (int i = 2; i < int'(LEN); i++) digit(1, "ce_rest");
        step(1'b1, 1'b1, 0, 1'b0, 1'b1, "prog2");
        digit(2, "p2"); digit(2, "p2"); digit(2, "p2");
        do_reset("reset_mid_prog");
        enter_seq(28'h3044238, "default_again");
        chk("default_unl", 32'(o_unlocked), 32'h1);

        // Relock beats program on the same cycle; digit with control is ignored.
        step(1'b1, 1'b0, 7, 1'b1, 1'b1, "relock_prio");
        chk("prio_unl", 32'(o_unlocked), 32'h0);
        chk("prio_prog", 32'(o_prog_active), 32'h0);

        // Aborted programming keeps the digits already written.
        enter_seq(28'h3044238, "unl3");
        step(1'b1, 1'b1, 0, 1'b0, 1'b1, "prog3");
        digit(5, "p5"); digit(5, "p5");
        step(1'b1, 1'b1, 0, 1'b1, 1'b0, "abort");
        enter_seq(28'h5544238, "partial_key");
        chk("partial_unl", 32'(o_unlocked), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic ce, sd, rl, pg;
            int d;
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rnd_reset");
            end else begin
                ce = ($urandom_range(0, 9) != 0);
                sd = ($urandom_range(0, 9) < 4);
                rl = ($urandom_range(0, 19) == 0);
                pg = ($urandom_range(0, 9) == 0);
                if (m_mode == 0 && $urandom_range(0, 9) < 8) d = m_key[m_pos];
                else d = int'($urandom_range(0, 15));
                step(ce, sd, d, rl, pg, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_lock_param.md
Name: fsm_lock_param

Overview:
Parametrised successor to the fixed 7-digit password lock. Compares a stream of W-bit digits against a stored key of P_LEN digits, reports progress as a thermometer acknowledge vector, and unlocks on full match. Adds a run-time reprogrammable key, a failed-attempt counter with timed lockout, and explicit relock. Sits between the keypad/digit front-end and the top-level status outputs.

Parameters:
P_DIG_W, 4, width of one digit
P_LEN, 7, number of digits in the key (>=2)
P_KEY, 28'h3044238, reset key; digit i = P_KEY[(P_LEN-1-i)*P_DIG_W +: P_DIG_W], so digit 0 is the leftmost hex digit
P_MAX_FAIL, 3, failed attempts that trigger lockout (>=1)
P_LOCKOUT, 16, lockout duration in enabled (i_CE=1) cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
i_Rst  in  1  reset, asynchronous, active-high
i_CE  in  1  clock enable; all state advances only when 1
i_set_data  in  1  digit strobe, active-low; a digit is accepted on a clk edge with i_CE=1 and i_set_data=0
iv_data  in  P_DIG_W  digit value
i_relock  in  1  return from UNLOCKED to ENTRY (sampled when i_CE=1)
i_prog  in  1  enter PROGRAM from UNLOCKED (sampled when i_CE=1)
o_acknowledge  out  P_LEN  thermometer progress; bit i set once digit i matched (ENTRY) or written (PROGRAM)
o_unlocked  out  1  high in UNLOCKED
o_prog_active  out  1  high in PROGRAM
o_locked_out  out  1  high in LOCKOUT
ov_fail_cnt  out  $clog2(P_MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- Reset (async, any time, incl. mid-entry/program/lockout): state=ENTRY, index=0, key=P_KEY, o_acknowledge=0, all flags 0, ov_fail_cnt=0, lockout timer=0.
- All outputs registered; visible the cycle after the accepting edge. With i_CE=0 everything holds.
- ENTRY, digit accepted:
  - iv_data == key[index]: ack[index]<=1, index++; if index was P_LEN-1 -> UNLOCKED, ov_fail_cnt<=0.
  - mismatch: ack<=0, index<=0, digit not re-evaluated as a new digit 0; ov_fail_cnt++; if new count == P_MAX_FAIL -> LOCKOUT, timer<=P_LOCKOUT.
- UNLOCKED: o_unlocked=1, ack all ones, digits ignored. Priority i_relock > i_prog. i_relock -> ENTRY, ack<=0, index<=0. i_prog -> PROGRAM, ack<=0, index<=0.
- PROGRAM: each accepted digit written to key[index], ack[index]<=1, index++; after digit P_LEN-1 -> ENTRY, ack<=0, index<=0 (device relocked with new key). i_relock aborts: -> ENTRY, partially written digits are kept (no shadow copy). i_prog ignored.
- LOCKOUT: digits, i_prog, i_relock ignored; ack=0; timer decrements per enabled cycle; on the enabled cycle where timer==1 -> ENTRY, ov_fail_cnt<=0. Duration exactly P_LOCKOUT enabled cycles.
- i_relock/i_prog in ENTRY: ignored. Simultaneous digit and i_relock/i_prog in UNLOCKED: the control wins and the digit is ignored.
- index width $clog2(P_LEN); never exceeds P_LEN-1. Illegal state encoding -> ENTRY with reset-equivalent outputs except key retained.

Decomposition:
- Package fsm_lock_pkg: state enum (ST_ENTRY, ST_UNLOCKED, ST_PROGRAM, ST_LOCKOUT), helper to extract digit i from a packed key.
- One sub-module: fsm_lock_keyram (P_LEN x P_DIG_W register array with async-reset init from P_KEY, one write port, one combinational read port by index).

Test Plan:
- Defaults, digits 3,0,4,4,2,3,8 with CE=1, set_data=0 -> ack 01,03,07,0F,1F,3F,7F; o_unlocked=1 after 7th digit, ov_fail_cnt=0.
- Digits 3,0,5 -> ack 03 then 00, ov_fail_cnt=1; next 3 -> ack 01 (restart works).
- Three wrong digits 9,9,9 -> o_locked_out=1 after third; correct sequence ignored for 16 enabled cycles; then ENTRY, ov_fail_cnt=0; full key unlocks.
- Unlock, i_prog=1, write 1,1,1,1,1,1,1 -> o_prog_active falls, ENTRY; old key 3044238 fails; 1111111 unlocks.
- Toggle i_CE=0 with set_data=0 mid-entry -> no state/ack change; i_Rst pulse mid-PROGRAM -> key back to 3044238, all outputs 0.
- UNLOCKED with i_relock=1 and i_prog=1 same cycle -> ENTRY (relock priority), o_unlocked=0, ack=0.
